// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, prioritised redirect and
// an optional circular return-address stack enabled by PC_UNIT_RAS_EN.
module pc_unit #(
  parameter int                 ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
  parameter int                 INC        = 2,
  parameter int                 RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pc_write,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_next,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [ADDR_W-1:0] seq_addr;

  assign seq_addr = pc_out + ADDR_W'(INC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out <= RESET_ADDR;
    end else if (pc_write) begin
      pc_out <= pc_next;
    end
  end

`ifdef PC_UNIT_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [PTR_W:0]    ras_cnt;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] ras_top;
  logic              have_top;
  logic              do_push;
  logic              do_replace;
  logic              do_pop;
  logic              do_unf;

  // ras_ptr names the next free slot; the top entry sits just below it and
  // the pointer wraps, so a push into a full stack lands on the oldest entry.
  assign top_idx    = ras_ptr - PTR_W'(1);
  assign ras_top    = ras_mem[top_idx];
  assign have_top   = (ras_cnt != '0);
  assign ras_empty  = !have_top;
  assign ras_full   = (ras_cnt == (PTR_W+1)'(RAS_DEPTH));

  assign do_push    = pc_write && call && (!ret || !have_top);
  assign do_replace = pc_write && call && ret && have_top;
  assign do_pop     = pc_write && ret && !call && have_top;
  assign do_unf     = pc_write && ret && !call && !have_top;

  always_comb begin
    pc_next = seq_addr;
    if (redirect_valid) begin
      pc_next = redirect_addr;
    end else if (ret && have_top) begin
      pc_next = ras_top;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[ras_ptr] <= seq_addr;
    end else if (do_replace) begin
      ras_mem[top_idx] <= seq_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      ras_unf <= do_unf;
      if (do_push) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (ras_full) begin
          ras_ovf <= 1'b1;
        end else begin
          ras_cnt <= ras_cnt + (PTR_W+1)'(1);
        end
      end else if (do_pop) begin
        ras_ptr <= top_idx;
        ras_cnt <= ras_cnt - (PTR_W+1)'(1);
      end
    end
  end
`else
  logic unused_ras_inputs;

  assign unused_ras_inputs = call | ret;
  assign pc_next   = redirect_valid ? redirect_addr : seq_addr;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Randomised and directed bench for pc_unit against a queue-based model;
// follows PC_UNIT_RAS_EN so it checks whichever build it is compiled with.
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_write;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        call;
  logic        ret;
  logic [15:0] pc_out;
  logic [15:0] pc_next;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  bit          m_ovf;
  bit          m_unf;

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_W(16), .RESET_ADDR(16'h0000), .INC(2), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .call(call), .ret(ret), .pc_out(pc_out), .pc_next(pc_next),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_next(input bit rv, input logic [15:0] ra, input bit r);
    if (rv) return ra;
    if (RAS_EN && r && m_q.size() > 0) return m_q[m_q.size()-1];
    return m_pc + 16'd2;
  endfunction

  task automatic check_state();
    check("pc_out", pc_out, m_pc);
    check("ras_empty", 16'(ras_empty), 16'(m_q.size() == 0));
    check("ras_full", 16'(ras_full), 16'(m_q.size() == DEPTH));
    check("ras_ovf", 16'(ras_ovf), 16'(m_ovf));
    check("ras_unf", 16'(ras_unf), 16'(m_unf));
  endtask

  // One clock of stimulus: drive at the falling edge, check pc_next before the
  // rising edge, advance the model on it, then check registered state.
  task automatic step(input bit pw, input bit rv, input logic [15:0] ra,
                      input bit c, input bit r);
    logic [15:0] exp_next;
    logic [15:0] seq;
    pc_write = pw; redirect_valid = rv; redirect_addr = ra; call = c; ret = r;
    #1;
    exp_next = model_next(rv, ra, r);
    check("pc_next", pc_next, exp_next);
    @(posedge clk);
    seq   = m_pc + 16'd2;
    m_unf = 1'b0;
    if (pw) begin
      if (RAS_EN) begin
        if (c && r) begin
          if (m_q.size() == 0) m_q.push_back(seq);
          else m_q[m_q.size()-1] = seq;
        end else if (c) begin
          m_q.push_back(seq);
          if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
          end
        end else if (r) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
          else m_unf = 1'b1;
        end
      end
      m_pc = exp_next;
    end
    @(negedge clk);
    check_state();
  endtask

  // Asynchronous reset asserted between edges, held across one rising edge.
  task automatic do_reset();
    pc_write = 1'b1; redirect_valid = 1'b0; call = 1'b0; ret = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    m_pc = 16'h0000; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_state();
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; pc_write = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 16'h0000; call = 1'b0; ret = 1'b0;
    m_pc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    check_state();
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0, 0);
    do_reset();
    check("reset_pc", pc_out, 16'h0000);
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0, 0);
    check("seq_third", pc_out, 16'h0006);

    step(1, 1, 16'hFFFC, 0, 0);
    step(1, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 0, 0);
    check("wrap", pc_out, 16'h0000);
    step(0, 1, 16'h5554, 1, 0);
    step(0, 1, 16'h5554, 1, 0);
    check("stall_hold", pc_out, 16'h0000);

    step(1, 1, 16'h00FE, 0, 0);
    step(1, 1, 16'h0500, 1, 0);
    step(1, 1, 16'h1234, 0, 1);
    check("redir_over_ret", pc_out, 16'h1234);

    step(1, 1, 16'h0040, 0, 0);
    step(1, 1, 16'h0200, 1, 0);
    check("call_redirect", pc_out, 16'h0200);
    step(1, 0, 16'h0, 0, 1);

    for (int i = 0; i < 5; i++) step(1, 0, 16'h0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0, 0, 1);
    step(1, 0, 16'h0, 0, 0);

    do_reset();
    step(1, 1, 16'h00FE, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    step(1, 1, 16'h0300, 0, 0);
    step(1, 0, 16'h0, 1, 1);
    step(1, 0, 16'h0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(4) != 0, $urandom_range(3) == 0,
             16'($urandom) & 16'hFFFE,
             $urandom_range(3) == 0, $urandom_range(2) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
